cpu_imm_extend_pipe: RTL and testbench



---
 rtl/cpu_imm_extend_pipe_pkg.sv | 23 ++
 rtl/cpu_imm_extend_pipe_if.sv | 30 +++
 rtl/cpu_imm_extend_pipe_format.sv | 52 +++++
 rtl/cpu_imm_extend_pipe.sv | 93 +++++++++
 tb/tb_cpu_imm_extend_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_imm_extend_pipe_pkg.sv
// Immediate-format encodings shared by the decode-stage immediate generator.
// I/S/B/U/J keep their historic codes; Z and SH are the newer formats, 3'b111 is reserved.
package cpu_imm_extend_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_SRC_I    = 3'b000,
    IMM_SRC_S    = 3'b001,
    IMM_SRC_B    = 3'b010,
    IMM_SRC_U    = 3'b011,
    IMM_SRC_J    = 3'b100,
    IMM_SRC_Z    = 3'b101,
    IMM_SRC_SH   = 3'b110,
    IMM_SRC_RSVD = 3'b111
  } imm_src_e;

  localparam int INSTR_W = 32;

  // Z and SH are unsigned fields; every other format sign-extends from instr[31].
  function automatic logic imm_src_is_signed(input imm_src_e src);
    return !(src == IMM_SRC_Z || src == IMM_SRC_SH);
  endfunction

endpackage

// File: rtl/cpu_imm_extend_pipe_if.sv
// Valid/ready bus between decode and the immediate pipe: request side in_*, result side out_*.
// master = upstream/downstream driver view, slave = the pipe itself.
interface cpu_imm_extend_pipe_if
  import cpu_imm_extend_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  imm_src_e            in_imm_src;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_imm;
  logic                out_illegal;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_illegal, out_tag
  );
endinterface

// File: rtl/cpu_imm_extend_pipe_format.sv
// Combinational immediate extraction: instr + format select -> XLEN immediate and illegal flag.
// Illegal formats force the immediate to zero so nothing downstream sees stale bits.
module cpu_imm_format
  import cpu_imm_extend_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  imm_src_e           i_imm_src,
  output logic [XLEN-1:0]    o_imm,
  output logic               o_illegal
);

  logic [31:0] w_raw;
  logic        w_unused;

  // Opcode bits never contribute to any immediate.
  assign w_unused = ^i_instr[6:0];

  always_comb begin
    w_raw     = '0;
    o_illegal = 1'b0;
    case (i_imm_src)
      IMM_SRC_I: w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_SRC_S: w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_SRC_B: w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_SRC_U: w_raw = {i_instr[31:12], 12'b0};
      IMM_SRC_J: w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      IMM_SRC_Z: w_raw = {27'b0, i_instr[19:15]};
      IMM_SRC_SH: begin
        if (XLEN == 64) begin
          w_raw = {26'b0, i_instr[25:20]};
        end else begin
          w_raw     = {27'b0, i_instr[24:20]};
          o_illegal = i_instr[25];
        end
      end
      default: o_illegal = 1'b1;
    endcase

    // The 32-bit raw value is already correctly extended to 32; widen once for RV64.
    if (o_illegal)
      o_imm = '0;
    else if (imm_src_is_signed(i_imm_src))
      o_imm = XLEN'($signed(w_raw));
    else
      o_imm = XLEN'(w_raw);
  end

endmodule

// File: rtl/cpu_imm_extend_pipe.sv
// Registered, handshaked immediate generator: one cycle from accept to out_*, order preserved.
// SKID=1 keeps a second entry so in_ready comes from a flop; SKID=0 passes out_ready back combinationally.
module cpu_imm_extend_pipe
  import cpu_imm_extend_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  cpu_imm_extend_pipe_if.slave  bus
);

  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic             w_in_rdy;
  logic             w_accept;
  logic             w_out_xfer;

  logic             r_main_vld;
  logic [XLEN-1:0]  r_main_imm;
  logic             r_main_ill;
  logic [TAG_W-1:0] r_main_tag;

  logic             r_skid_vld;
  logic [XLEN-1:0]  r_skid_imm;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;

  logic             r_in_rdy;

  cpu_imm_format #(.XLEN(XLEN)) u_format (
    .i_instr   (bus.in_instr),
    .i_imm_src (bus.in_imm_src),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_in_rdy   = (SKID != 0) ? r_in_rdy : (!r_main_vld || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_rdy && !flush;
  assign w_out_xfer = r_main_vld && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_main_imm <= '0;
      r_main_ill <= 1'b0;
      r_main_tag <= '0;
      r_skid_vld <= 1'b0;
      r_skid_imm <= '0;
      r_skid_ill <= 1'b0;
      r_skid_tag <= '0;
      r_in_rdy   <= 1'b1;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else if (r_skid_vld) begin
      // Upstream is stalled while skid holds a token; drain it into main on the next transfer.
      if (w_out_xfer) begin
        r_main_imm <= r_skid_imm;
        r_main_ill <= r_skid_ill;
        r_main_tag <= r_skid_tag;
        r_skid_vld <= 1'b0;
        r_in_rdy   <= 1'b1;
      end
    end else if (w_accept) begin
      if (!r_main_vld || w_out_xfer) begin
        r_main_vld <= 1'b1;
        r_main_imm <= w_imm;
        r_main_ill <= w_illegal;
        r_main_tag <= bus.in_tag;
      end else begin
        r_skid_vld <= 1'b1;
        r_skid_imm <= w_imm;
        r_skid_ill <= w_illegal;
        r_skid_tag <= bus.in_tag;
        r_in_rdy   <= 1'b0;
      end
    end else if (w_out_xfer) begin
      r_main_vld <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_rdy;
  assign bus.out_valid   = r_main_vld;
  assign bus.out_imm     = r_main_imm;
  assign bus.out_illegal = r_main_ill;
  assign bus.out_tag     = r_main_tag;

endmodule

// File: tb/tb_cpu_imm_extend_pipe.sv
// Bench for cpu_imm_extend_pipe: format vectors on RV32/RV64, skid ordering, streaming,
// SKID=0 ready path, flush and asynchronous reset.
module tb_cpu_imm_extend_pipe;
  import cpu_imm_extend_pipe_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cpu_imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) b32();
  cpu_imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) b64();
  cpu_imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) b0();

  cpu_imm_extend_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32));
  cpu_imm_extend_pipe #(.XLEN(64), .TAG_W(5), .SKID(1)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b64));
  cpu_imm_extend_pipe #(.XLEN(32), .TAG_W(5), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b0));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    imm_src_e    src;
    logic [31:0] instr;
    logic [31:0] e32;
    logic        il32;
    logic [63:0] e64;
    logic        il64;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{IMM_SRC_I,    32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1]  = '{IMM_SRC_S,    32'hFE20AE23, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[2]  = '{IMM_SRC_J,    32'hFFDFF06F, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[3]  = '{IMM_SRC_U,    32'h800000B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vt[4]  = '{IMM_SRC_U,    32'h123450B7, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vt[5]  = '{IMM_SRC_SH,   32'h03F09093, 32'h00000000, 1'b1, 64'h000000000000003F, 1'b0};
    vt[6]  = '{IMM_SRC_Z,    32'h000F8073, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vt[7]  = '{IMM_SRC_B,    32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[8]  = '{IMM_SRC_RSVD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vt[9]  = '{IMM_SRC_SH,   32'h01F09093, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vt[10] = '{IMM_SRC_I,    32'h7FF00093, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
    vt[11] = '{IMM_SRC_S,    32'h00A12423, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vt[12] = '{IMM_SRC_Z,    32'h800F8073, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};

    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_imm_src = IMM_SRC_I; b32.in_tag = '0; b32.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_imm_src = IMM_SRC_I; b64.in_tag = '0; b64.out_ready = 1'b0;
    b0.in_valid  = 1'b0; b0.in_instr  = '0; b0.in_imm_src  = IMM_SRC_I; b0.in_tag  = '0; b0.out_ready  = 1'b0;

    // Reset state while rst is held
    #12;
    chk("rst_out_valid32", b32.out_valid, 0);
    chk("rst_in_ready32",  b32.in_ready, 1);
    chk("rst_out_imm32",   b32.out_imm, 0);
    chk("rst_out_ill32",   b32.out_illegal, 0);
    chk("rst_out_tag32",   b32.out_tag, 0);
    chk("rst_out_valid64", b64.out_valid, 0);
    chk("rst_out_imm64",   b64.out_imm, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Format table, applied to RV32 and RV64 in parallel
    b32.out_ready = 1'b1;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      b32.in_valid = 1'b1; b32.in_instr = vt[i].instr; b32.in_imm_src = vt[i].src; b32.in_tag = 5'(i);
      b64.in_valid = 1'b1; b64.in_instr = vt[i].instr; b64.in_imm_src = vt[i].src; b64.in_tag = 5'(i);
      step();
      b32.in_valid = 1'b0;
      b64.in_valid = 1'b0;
      chk($sformatf("v%0d_valid32", i), b32.out_valid, 1);
      chk($sformatf("v%0d_imm32", i),   b32.out_imm, vt[i].e32);
      chk($sformatf("v%0d_ill32", i),   b32.out_illegal, vt[i].il32);
      chk($sformatf("v%0d_tag32", i),   b32.out_tag, 5'(i));
      chk($sformatf("v%0d_imm64", i),   b64.out_imm, vt[i].e64);
      chk($sformatf("v%0d_ill64", i),   b64.out_illegal, vt[i].il64);
    end
    step();
    chk("drain_valid32", b32.out_valid, 0);

    // Skid: stall output, push tags 1,2,3
    b32.out_ready = 1'b0;
    b32.in_imm_src = IMM_SRC_I;
    b32.in_valid = 1'b1; b32.in_tag = 5'd1; b32.in_instr = 32'h00100093;
    chk("skid_rdy_t1", b32.in_ready, 1);
    step();
    chk("skid_tag1_out", b32.out_tag, 1);
    chk("skid_rdy_t2", b32.in_ready, 1);
    b32.in_tag = 5'd2; b32.in_instr = 32'h00200093;
    step();
    chk("skid_rdy_drop", b32.in_ready, 0);
    chk("skid_hold_tag_a", b32.out_tag, 1);
    b32.in_tag = 5'd3; b32.in_instr = 32'h00300093;
    step();
    chk("skid_rdy_low", b32.in_ready, 0);
    chk("skid_hold_tag_b", b32.out_tag, 1);
    chk("skid_hold_imm", b32.out_imm, 1);
    step();
    chk("skid_hold_valid", b32.out_valid, 1);
    chk("skid_hold_tag_c", b32.out_tag, 1);
    b32.out_ready = 1'b1;
    step();
    chk("skid_out2_valid", b32.out_valid, 1);
    chk("skid_out2_tag", b32.out_tag, 2);
    chk("skid_out2_imm", b32.out_imm, 2);
    chk("skid_rdy_back", b32.in_ready, 1);
    step();
    b32.in_valid = 1'b0;
    chk("skid_out3_valid", b32.out_valid, 1);
    chk("skid_out3_tag", b32.out_tag, 3);
    chk("skid_out3_imm", b32.out_imm, 3);
    step();
    chk("skid_empty", b32.out_valid, 0);

    // Streaming 8 tokens through RV64
    b64.out_ready = 1'b1;
    b64.in_imm_src = IMM_SRC_I;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        b64.in_valid = 1'b1; b64.in_tag = 5'(8 + i); b64.in_instr = {12'(i), 20'h00093};
        chk($sformatf("stream_rdy%0d", i), b64.in_ready, 1);
      end else begin
        b64.in_valid = 1'b0;
      end
      if (i > 0) begin
        chk($sformatf("stream_valid%0d", i - 1), b64.out_valid, 1);
        chk($sformatf("stream_tag%0d", i - 1),   b64.out_tag, 5'(8 + i - 1));
        chk($sformatf("stream_imm%0d", i - 1),   b64.out_imm, 64'(i - 1));
      end
      step();
    end
    chk("stream_drain", b64.out_valid, 0);

    // SKID=0: in_ready follows out_ready combinationally
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b1; b0.in_tag = 5'd5; b0.in_instr = 32'h00500093;
    chk("s0_rdy_empty", b0.in_ready, 1);
    step();
    b0.in_valid = 1'b0;
    chk("s0_valid", b0.out_valid, 1);
    chk("s0_tag", b0.out_tag, 5);
    chk("s0_rdy_stall", b0.in_ready, 0);
    b0.out_ready = 1'b1;
    #1;
    chk("s0_rdy_comb", b0.in_ready, 1);
    step();
    chk("s0_drain", b0.out_valid, 0);

    // Flush with a full skid and a token waiting upstream
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_tag = 5'd10; b32.in_instr = 32'h00A00093;
    step();
    b32.in_tag = 5'd11; b32.in_instr = 32'h00B00093;
    step();
    chk("fl_skid_full", b32.in_ready, 0);
    b32.in_tag = 5'd12; b32.in_instr = 32'h00C00093;
    flush = 1'b1;
    step();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("fl_valid", b32.out_valid, 0);
    chk("fl_rdy", b32.in_ready, 1);
    b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), b32.out_valid, 0);
    end

    // Flush wins over a same-cycle accept
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_tag = 5'd13; b32.in_instr = 32'h00D00093;
    flush = 1'b1;
    step();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("fl_drop_valid", b32.out_valid, 0);

    // Asynchronous reset mid-transfer
    b32.in_valid = 1'b1; b32.in_tag = 5'd20; b32.in_instr = 32'h01400093;
    step();
    chk("ar_pre_valid", b32.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", b32.out_valid, 0);
    chk("ar_rdy", b32.in_ready, 1);
    chk("ar_tag", b32.out_tag, 0);
    chk("ar_imm", b32.out_imm, 0);
    b32.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    step();
    chk("ar_after", b32.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
